// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder with valid/ready in and out handshakes.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b mode).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] dig_ext;
  logic [DIGIT:0]   dig_sum;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;
  logic             accept;
  logic             last;
  logic             take;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract is a + ~b + 1; carry_out then means "no borrow".
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub ? 1'b1 : carry_in;
`else
  assign b_ld = b;
  assign c_ld = carry_in;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && (state == IDLE);
  assign last     = (cnt == CW'(STEPS - 1));
  assign take     = out_ready && (state == DONE);

  always_comb begin
    dig_sum = {1'b0, a_sh[DIGIT-1:0]}
            + {1'b0, b_sh[DIGIT-1:0]}
            + {{DIGIT{1'b0}}, carry};
    dig_ext = WIDTH'(dig_sum[DIGIT-1:0]);
    // New digit enters at the MSB end so the LSB digit lands at bit 0.
    acc_nx  = (acc >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): if (accept) state_nx = RUN;
      (state == RUN):  if (last) state_nx = DONE;
      (state == DONE): if (take) state_nx = IDLE;
      default:         state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_ld;
      acc   <= '0;
      carry <= c_ld;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      acc   <= acc_nx;
      carry <= dig_sum[DIGIT];
      cnt   <= cnt + CW'(1);
    end
  end

  // Result regs update only on the final digit so they hold between ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if ((state == RUN) && last) begin
      out_valid <= 1'b1;
      sum       <= acc_nx;
      carry_out <= dig_sum[DIGIT];
    end else if (take) begin
      out_valid <= 1'b0;
    end
  end

endmodule
